// File: rtl/hdmi_packet_scheduler.sv
// hdmi_packet_scheduler: grants 32-pixel HDMI data-island packet slots round-robin, null-filling idle slots.
// Define HDMI_SCHED_GUARD_EN to frame each island with 2-cycle leading/trailing guard bands.
module hdmi_packet_scheduler #(
  parameter int NUM_REQ     = 4,
  parameter int MAX_PACKETS = 18,
  parameter int LEN_W       = 5
) (
  input  logic                   clk_pixel,
  input  logic                   reset,
  input  logic                   island_start,
  input  logic [LEN_W-1:0]       island_len,
  input  logic                   island_abort,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [NUM_REQ*24-1:0]  req_header,
  input  logic [NUM_REQ*224-1:0] req_sub,
  output logic [NUM_REQ-1:0]     req_ack,
  output logic                   data_island_period,
  output logic                   guard_band,
  output logic [23:0]            header,
  output logic [223:0]           sub_flat,
  output logic [4:0]             slot_counter,
  output logic                   busy
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(MAX_PACKETS + 1);

  typedef enum logic [1:0] {IDLE, LEAD, ACTIVE, TRAIL} state_t;

  state_t           state;
  logic [PTR_W-1:0] rr_ptr;
  logic [CNT_W-1:0] slots_left;
  logic             abort_hold;
`ifdef HDMI_SCHED_GUARD_EN
  logic             guard_phase;
`endif

  logic [CNT_W-1:0]   len_m1;
  logic [23:0]        hdr_arr [NUM_REQ];
  logic [223:0]       sub_arr [NUM_REQ];
  logic               pick_found;
  logic [PTR_W-1:0]   pick_idx;
  logic [PTR_W-1:0]   pick_ptr;
  logic [NUM_REQ-1:0] pick_ack;
  logic [23:0]        pick_header;
  logic [223:0]       pick_sub;
  int unsigned        cand;
  logic               slot_end;
  logic               island_done;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign hdr_arr[g] = req_header[24*g +: 24];
    assign sub_arr[g] = req_sub[224*g +: 224];
  end

  // Slot count minus one; over-long islands are clamped to MAX_PACKETS.
  always_comb begin
    if (32'(island_len) > 32'(MAX_PACKETS)) len_m1 = CNT_W'(MAX_PACKETS - 1);
    else                                    len_m1 = CNT_W'(32'(island_len) - 32'd1);
  end

  // Round-robin search starting at rr_ptr, wrapping modulo NUM_REQ.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = 0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand = 32'(rr_ptr) + k;
      if (cand >= 32'(NUM_REQ)) cand = cand - 32'(NUM_REQ);
      if (!pick_found && req_valid[PTR_W'(cand)]) begin
        pick_found = 1'b1;
        pick_idx   = PTR_W'(cand);
      end
    end
    pick_ack    = '0;
    pick_header = '0;
    pick_sub    = '0;
    pick_ptr    = rr_ptr;
    if (pick_found) begin
      pick_ack[pick_idx] = 1'b1;
      pick_header        = hdr_arr[pick_idx];
      pick_sub           = sub_arr[pick_idx];
      pick_ptr           = (pick_idx == PTR_W'(NUM_REQ - 1)) ? '0 : pick_idx + 1'b1;
    end
  end

  assign slot_end    = (slot_counter == 5'd31);
  assign island_done = (slots_left == '0) || abort_hold || island_abort;

`ifndef HDMI_SCHED_GUARD_EN
  assign guard_band = 1'b0;
`endif

  always_ff @(posedge clk_pixel or posedge reset) begin
    if (reset) begin
      state              <= IDLE;
      rr_ptr             <= '0;
      slots_left         <= '0;
      abort_hold         <= 1'b0;
      req_ack            <= '0;
      data_island_period <= 1'b0;
      header             <= '0;
      sub_flat           <= '0;
      slot_counter       <= '0;
      busy               <= 1'b0;
`ifdef HDMI_SCHED_GUARD_EN
      guard_band         <= 1'b0;
      guard_phase        <= 1'b0;
`endif
    end else begin
      req_ack <= '0;
      case (state)
        IDLE: begin
          if (island_start && island_len != '0) begin
            slots_left <= len_m1;
            abort_hold <= 1'b0;
            busy       <= 1'b1;
`ifdef HDMI_SCHED_GUARD_EN
            state       <= LEAD;
            guard_band  <= 1'b1;
            guard_phase <= 1'b0;
`else
            state              <= ACTIVE;
            data_island_period <= 1'b1;
            slot_counter       <= '0;
            req_ack            <= pick_ack;
            header             <= pick_header;
            sub_flat           <= pick_sub;
            rr_ptr             <= pick_ptr;
`endif
          end
        end
`ifdef HDMI_SCHED_GUARD_EN
        // First slot is arbitrated on the final lead cycle so it starts with the island.
        LEAD: begin
          guard_phase <= ~guard_phase;
          if (guard_phase) begin
            state              <= ACTIVE;
            guard_band         <= 1'b0;
            data_island_period <= 1'b1;
            slot_counter       <= '0;
            req_ack            <= pick_ack;
            header             <= pick_header;
            sub_flat           <= pick_sub;
            rr_ptr             <= pick_ptr;
          end
        end
`endif
        ACTIVE: begin
          slot_counter <= slot_counter + 5'd1;
          if (island_abort) abort_hold <= 1'b1;
          if (slot_end) begin
            if (island_done) begin
              data_island_period <= 1'b0;
              header             <= '0;
              sub_flat           <= '0;
`ifdef HDMI_SCHED_GUARD_EN
              state       <= TRAIL;
              guard_band  <= 1'b1;
              guard_phase <= 1'b0;
`else
              state <= IDLE;
              busy  <= 1'b0;
`endif
            end else begin
              slots_left <= slots_left - 1'b1;
              req_ack    <= pick_ack;
              header     <= pick_header;
              sub_flat   <= pick_sub;
              rr_ptr     <= pick_ptr;
            end
          end
        end
`ifdef HDMI_SCHED_GUARD_EN
        TRAIL: begin
          guard_phase <= ~guard_phase;
          if (guard_phase) begin
            state      <= IDLE;
            guard_band <= 1'b0;
            busy       <= 1'b0;
          end
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hdmi_packet_scheduler.sv
// tb_hdmi_packet_scheduler: directed and randomized islands checked against a slot-level reference model.
// Honours HDMI_SCHED_GUARD_EN when the design is built with guard bands.
module tb_hdmi_packet_scheduler;
  localparam int NREQ = 4;
  localparam int MAXP = 18;

  logic                clk = 1'b0;
  logic                reset = 1'b1;
  logic                island_start = 1'b0;
  logic                island_abort = 1'b0;
  logic [4:0]          island_len = '0;
  logic [NREQ-1:0]     req_valid = '0;
  logic [NREQ*24-1:0]  req_header = '0;
  logic [NREQ*224-1:0] req_sub = '0;
  logic [NREQ-1:0]     req_ack;
  logic                data_island_period;
  logic                guard_band;
  logic                busy;
  logic [23:0]         header;
  logic [223:0]        sub_flat;
  logic [4:0]          slot_counter;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;
  int mptr     = 0;
  logic [23:0]  hdr_m [NREQ];
  logic [223:0] sub_m [NREQ];
  int grants[$];

  hdmi_packet_scheduler #(.NUM_REQ(NREQ), .MAX_PACKETS(MAXP), .LEN_W(5)) dut (
    .clk_pixel(clk), .reset(reset), .island_start(island_start), .island_len(island_len),
    .island_abort(island_abort), .req_valid(req_valid), .req_header(req_header), .req_sub(req_sub),
    .req_ack(req_ack), .data_island_period(data_island_period), .guard_band(guard_band),
    .header(header), .sub_flat(sub_flat), .slot_counter(slot_counter), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL watchdog: observed timeout, required completion");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Winner = first pending source at or after the pointer, wrapping.
  function automatic int pick(input logic [NREQ-1:0] v, input int ptr);
    for (int k = 0; k < NREQ; k++)
      if (v[2'((ptr + k) % NREQ)]) return (ptr + k) % NREQ;
    return -1;
  endfunction

  task automatic set_sources();
    for (int i = 0; i < NREQ; i++) begin
      hdr_m[2'(i)] = 24'($urandom) | 24'h1;
      for (int k = 0; k < 7; k++) sub_m[2'(i)][32*k +: 32] = $urandom;
      req_header[24*i +: 24]   = hdr_m[2'(i)];
      req_sub[224*i +: 224]    = sub_m[2'(i)];
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    mptr  = 0;
  endtask

  task automatic run_island(input int len, input int abort_slot, input int abort_cnt,
                            input bit chg, input bit poke, output int cyc);
    int slots, w, got, exp_slots, ack_extra;
    bit last, aborted, bad;
    logic [NREQ-1:0] exp_ack;
    logic [23:0]     eh;
    logic [223:0]    es;
    slots     = (len > MAXP) ? MAXP : len;
    cyc       = 0;
    exp_slots = 0;
    ack_extra = 0;
    aborted   = 1'b0;
    last      = 1'b0;
    island_start = 1'b1;
    island_len   = 5'(len);
    w = pick(req_valid, mptr);
    step();
    island_start = 1'b0;
    island_len   = '0;
    if (len == 0) begin
      chk("len0_ignored", 256'({busy, data_island_period, guard_band, req_ack}), '0);
      step();
      chk("len0_still_idle", 256'({busy, data_island_period, guard_band, req_ack}), '0);
      return;
    end
`ifdef HDMI_SCHED_GUARD_EN
    repeat (2) begin
      chk("lead", 256'({guard_band, data_island_period, busy, req_ack}), 256'({3'b101, 4'b0}));
      step();
    end
`endif
    for (int s = 0; s < slots; s++) begin
      exp_ack = '0;
      eh      = '0;
      es      = '0;
      if (w >= 0) begin
        exp_ack = 4'(32'd1 << w);
        eh      = hdr_m[2'(w)];
        es      = sub_m[2'(w)];
        mptr    = (w + 1) % NREQ;
      end
      got = -1;
      for (int i = 0; i < NREQ; i++) if (req_ack[2'(i)]) got = i;
      grants.push_back(got);
      chk($sformatf("slot%0d_start", s), 256'({data_island_period, busy, slot_counter, req_ack}),
          256'({2'b11, 5'd0, exp_ack}));
      bad = 1'b0;
      exp_slots++;
      for (int c = 0; c < 32; c++) begin
        island_abort = 1'b0;
        island_start = 1'b0;
        island_len   = '0;
        if (header !== eh || sub_flat !== es || slot_counter !== 5'(c) ||
            data_island_period !== 1'b1 || guard_band !== 1'b0) bad = 1'b1;
        if (data_island_period) cyc++;
        if (c != 0 && req_ack !== '0) ack_extra++;
        if (s == abort_slot && c == abort_cnt) begin
          island_abort = 1'b1;
          aborted      = 1'b1;
        end
        if (poke && s == 0 && c == 5) begin
          island_start = 1'b1;
          island_len   = 5'd3;
        end
        if (chg && c == 15) req_valid = NREQ'($urandom);
        if (c == 31) begin
          last = (s == slots - 1) || aborted;
          if (!last) w = pick(req_valid, mptr);
        end
        step();
      end
      chk($sformatf("slot%0d_hold", s), 256'(bad), '0);
      if (last) break;
    end
    island_abort = 1'b0;
    island_start = 1'b0;
    island_len   = '0;
    chk("end_clear_a", 256'({data_island_period, req_ack, header}), '0);
    chk("end_clear_sub", 256'(sub_flat), '0);
    chk("dip_cycles", 256'(cyc), 256'(32 * exp_slots));
    chk("ack_extra", 256'(ack_extra), '0);
`ifdef HDMI_SCHED_GUARD_EN
    repeat (2) begin
      chk("trail", 256'({guard_band, busy, data_island_period}), 256'(3'b110));
      step();
    end
`endif
    chk("idle_after", 256'({busy, guard_band}), '0);
  endtask

  initial begin
    int cyc, len, sl, ab_s, ab_c;
    int rr_exp[6] = '{0, 1, 2, 3, 0, 1};

    step();
    chk("reset_a", 256'({req_ack, data_island_period, guard_band, busy, slot_counter, header}), '0);
    chk("reset_sub", 256'(sub_flat), '0);
    reset = 1'b0;
    step();
    chk("idle_after_reset", 256'({busy, data_island_period, req_ack}), '0);

    // Basic single slot
    set_sources();
    req_valid = 4'b0001;
    grants.delete();
    run_island(1, -1, 0, 1'b0, 1'b0, cyc);
    chk("basic_cycles", 256'(cyc), 256'(32));
    chk("basic_grant", 256'(grants[0]), 256'(0));

    // Round-robin order from a fresh pointer
    do_reset();
    req_valid = '1;
    grants.delete();
    run_island(6, -1, 0, 1'b0, 1'b0, cyc);
    for (int i = 0; i < 6; i++) chk($sformatf("rr_order%0d", i), 256'(grants[i]), 256'(rr_exp[i]));
    grants.delete();
    run_island(1, -1, 0, 1'b0, 1'b0, cyc);
    chk("rr_ptr_after", 256'(grants[0]), 256'(2));

    // Null fill leaves the pointer alone (pointer now 3)
    req_valid = '0;
    grants.delete();
    run_island(3, -1, 0, 1'b0, 1'b0, cyc);
    chk("null_cycles", 256'(cyc), 256'(96));
    req_valid = '1;
    grants.delete();
    run_island(1, -1, 0, 1'b0, 1'b0, cyc);
    chk("null_ptr_kept", 256'(grants[0]), 256'(3));

    // Boundaries
    run_island(0, -1, 0, 1'b0, 1'b0, cyc);
    set_sources();
    req_valid = 4'b1010;
    run_island(31, -1, 0, 1'b1, 1'b0, cyc);
    chk("clamp_cycles", 256'(cyc), 256'(576));
    run_island(2, -1, 0, 1'b0, 1'b1, cyc);
    chk("start_while_busy", 256'(cyc), 256'(64));

    // Abort mid-slot and on the boundary cycle
    req_valid = '1;
    run_island(5, 1, 10, 1'b0, 1'b0, cyc);
    chk("abort_cycles", 256'(cyc), 256'(64));
    run_island(4, 0, 31, 1'b0, 1'b0, cyc);
    chk("abort_boundary_cycles", 256'(cyc), 256'(32));

    // Asynchronous reset in the middle of slot 2
    do_reset();
    set_sources();
    req_valid    = '1;
    island_start = 1'b1;
    island_len   = 5'd5;
    step();
    island_start = 1'b0;
    island_len   = '0;
`ifdef HDMI_SCHED_GUARD_EN
    repeat (2) step();
`endif
    repeat (71) step();
    chk("pre_reset_pos", 256'({data_island_period, slot_counter}), 256'({1'b1, 5'd7}));
    reset = 1'b1;
    #1;
    chk("reset_mid_a", 256'({req_ack, data_island_period, guard_band, busy, slot_counter, header}), '0);
    chk("reset_mid_sub", 256'(sub_flat), '0);
    step();
    reset = 1'b0;
    mptr  = 0;
    grants.delete();
    run_island(1, -1, 0, 1'b0, 1'b0, cyc);
    chk("post_reset_grant", 256'(grants[0]), 256'(0));

    // Randomized islands against the model
    for (int n = 0; n < 15; n++) begin
      set_sources();
      req_valid = NREQ'($urandom);
      len  = ($urandom_range(0, 4) == 0) ? int'($urandom_range(19, 31)) : int'($urandom_range(0, 8));
      sl   = (len > MAXP) ? MAXP : len;
      ab_s = -1;
      ab_c = 0;
      if (sl > 0 && $urandom_range(0, 2) == 0) begin
        ab_s = int'($urandom_range(0, sl - 1));
        ab_c = int'($urandom_range(0, 31));
      end
      run_island(len, ab_s, ab_c, 1'($urandom), 1'($urandom), cyc);
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
